// File: rtl/des_round_ctrl_if.sv
// Controller-facing bundle: block source handshake, shared round datapath strobes, result sink.
// DES_DECRYPT_EN adds the per-block mode bit (0 = encrypt, 1 = decrypt).
interface des_round_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int KEY_W  = 56
);
  logic              in_valid;
  logic              in_ready;
  logic [KEY_W-1:0]  in_key;
`ifdef DES_DECRYPT_EN
  logic              mode;
`endif
  logic              dp_load;
  logic              dp_round_en;
  logic              dp_last;
  logic [3:0]        rnd_idx;
  logic [KEY_W-1:0]  round_key_cd;
  logic [DATA_W-1:0] dp_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  modport slave (
    input  in_valid, in_key, dp_result, out_ready,
`ifdef DES_DECRYPT_EN
    input  mode,
`endif
    output in_ready, dp_load, dp_round_en, dp_last, rnd_idx, round_key_cd,
    output out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_key, dp_result, out_ready,
`ifdef DES_DECRYPT_EN
    output mode,
`endif
    input  in_ready, dp_load, dp_round_en, dp_last, rnd_idx, round_key_cd,
    input  out_valid, out_data, busy
  );
endinterface

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: owns the C/D key schedule and round counter for a shared
// single-round datapath. Define DES_DECRYPT_EN to add the decrypt (right-rotate) schedule.
module des_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int DATA_W = 64,
  parameter int KEY_W  = 56
) (
  input  logic            clk,
  input  logic            rst,
  des_round_ctrl_if.slave bus
);
  localparam int         HALF     = KEY_W / 2;
  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_CAPT,
    S_OUT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [KEY_W-1:0]  cd;
  logic [KEY_W-1:0]  cd_nxt;
  logic [3:0]        rnd;
  logic [3:0]        rnd_nxt;
  logic [DATA_W-1:0] out_q;
  logic              accept;
  logic              last_rnd;
`ifdef DES_DECRYPT_EN
  logic              dec;
`endif

  // DES left-shift schedule: single shifts at rounds 1, 2, 9 and 16, double elsewhere.
  function automatic logic [1:0] shift_amt(input logic [3:0] i);
    case (i)
      4'd0, 4'd1, 4'd8, 4'd15: shift_amt = 2'd1;
      default:                 shift_amt = 2'd2;
    endcase
  endfunction

  function automatic logic [HALF-1:0] rotl_half(input logic [HALF-1:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotl_half = {x[HALF-2:0], x[HALF-1]};
      2'd2:    rotl_half = {x[HALF-3:0], x[HALF-1:HALF-2]};
      default: rotl_half = x;
    endcase
  endfunction

  function automatic logic [KEY_W-1:0] rotl_cd(input logic [KEY_W-1:0] x, input logic [1:0] n);
    rotl_cd = {rotl_half(x[KEY_W-1:HALF], n), rotl_half(x[HALF-1:0], n)};
  endfunction

`ifdef DES_DECRYPT_EN
  function automatic logic [HALF-1:0] rotr_half(input logic [HALF-1:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotr_half = {x[0], x[HALF-1:1]};
      2'd2:    rotr_half = {x[1:0], x[HALF-1:2]};
      default: rotr_half = x;
    endcase
  endfunction

  function automatic logic [KEY_W-1:0] rotr_cd(input logic [KEY_W-1:0] x, input logic [1:0] n);
    rotr_cd = {rotr_half(x[KEY_W-1:HALF], n), rotr_half(x[HALF-1:0], n)};
  endfunction
`endif

  assign accept   = (state == S_IDLE) && bus.in_valid;
  assign last_rnd = (rnd == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // in_ready is gated by rst so the source sees no acceptance while reset is held.
  always_comb begin
    state_nxt       = state;
    bus.in_ready    = 1'b0;
    bus.dp_load     = 1'b0;
    bus.dp_round_en = 1'b0;
    bus.dp_last     = 1'b0;
    bus.out_valid   = 1'b0;
    bus.busy        = 1'b1;
    case (state)
      S_IDLE: begin
        bus.busy     = 1'b0;
        bus.in_ready = rst;
        if (bus.in_valid) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        bus.dp_load = 1'b1;
        state_nxt   = S_ROUND;
      end
      S_ROUND: begin
        bus.dp_round_en = 1'b1;
        bus.dp_last     = last_rnd;
        if (last_rnd) state_nxt = S_CAPT;
      end
      S_CAPT: state_nxt = S_OUT;
      S_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Key schedule advances one step per round and freezes on the final round.
  always_comb begin
    cd_nxt  = cd;
    rnd_nxt = rnd;
    if (accept) begin
      rnd_nxt = 4'd0;
`ifdef DES_DECRYPT_EN
      cd_nxt  = bus.mode ? bus.in_key : rotl_cd(bus.in_key, shift_amt(4'd0));
`else
      cd_nxt  = rotl_cd(bus.in_key, shift_amt(4'd0));
`endif
    end else if ((state == S_ROUND) && !last_rnd) begin
      rnd_nxt = rnd + 4'd1;
`ifdef DES_DECRYPT_EN
      cd_nxt  = dec ? rotr_cd(cd, shift_amt(4'd15 - rnd)) : rotl_cd(cd, shift_amt(rnd + 4'd1));
`else
      cd_nxt  = rotl_cd(cd, shift_amt(rnd + 4'd1));
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd    <= '0;
      rnd   <= '0;
      out_q <= '0;
`ifdef DES_DECRYPT_EN
      dec   <= 1'b0;
`endif
    end else begin
      cd  <= cd_nxt;
      rnd <= rnd_nxt;
      if (state == S_CAPT) out_q <= bus.dp_result;
`ifdef DES_DECRYPT_EN
      if (accept) dec <= bus.mode;
`endif
    end
  end

  assign bus.round_key_cd = cd;
  assign bus.rnd_idx      = rnd;
  assign bus.out_data     = out_q;
endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: a behavioural DES round datapath plus a textbook DES reference model.
// Decrypt scenarios are compiled in when DES_DECRYPT_EN is defined.
module tb_des_round_ctrl;
  localparam int ROUNDS = 16;
  localparam int DATA_W = 64;
  localparam int KEY_W  = 56;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  des_round_ctrl_if #(.DATA_W(DATA_W), .KEY_W(KEY_W)) bus ();
  des_round_ctrl #(.ROUNDS(ROUNDS), .DATA_W(DATA_W), .KEY_W(KEY_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  localparam int SE[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int IP_T[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                              62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                              57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                              61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T[64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                              38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                              36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                              34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T[48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                             16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T[32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                             2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  localparam int PC1_T[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                               19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                               14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                               41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam logic [255:0] SBOX[8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = k[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = cd[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0]  e;
    logic [31:0]  s;
    logic [31:0]  y;
    logic [255:0] sb;
    logic [5:0]   b;
    int           idx;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = e[47-6*j -: 6];
      idx = int'({b[5], b[0]}) * 16 + int'(b[4:1]);
      sb  = SBOX[j];
      s[31-4*j -: 4] = sb[255-4*idx -: 4];
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    logic [55:0] d;
    d = {x, x};
    return d[55-n -: 28];
  endfunction

  // C_n||D_n: the PC-1 key rotated left by the cumulative shift count of rounds 1..n.
  function automatic logic [55:0] cd_ref(input logic [55:0] key, input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s += SE[i];
    s = s % 28;
    return {rotl28(key[55:28], s), rotl28(key[27:0], s)};
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] m, input logic [55:0] key, input logic dec);
    logic [63:0] x;
    logic [31:0] l, r, t;
    int          kn;
    x = ip(m);
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < ROUNDS; i++) begin
      kn = dec ? 16 - i : i + 1;
      t  = r;
      r  = l ^ des_f(r, pc2(cd_ref(key, kn)));
      l  = t;
    end
    return fp({r, l});
  endfunction

  // External single-round datapath: L/R register, swap skipped on the last round.
  logic [63:0] msg  = '0;
  logic [63:0] lr   = '0;
  logic [63:0] junk = '0;

  function automatic logic [63:0] dp_round(input logic [63:0] x, input logic [55:0] cd, input logic last);
    logic [31:0] t;
    t = x[63:32] ^ des_f(x[31:0], pc2(cd));
    return last ? {t, x[31:0]} : {x[31:0], t};
  endfunction

  always @(posedge clk) begin
    if (bus.dp_load)          lr <= ip(msg);
    else if (bus.dp_round_en) lr <= dp_round(lr, bus.round_key_cd, bus.dp_last);
  end

  always_comb bus.dp_result = fp(lr) ^ junk;

  function automatic logic [5:0] strobes();
    return {bus.dp_load, bus.dp_round_en, bus.dp_last, bus.out_valid, bus.in_ready, bus.busy};
  endfunction

  task automatic run_block(input logic [55:0] key, input logic [63:0] m, input logic dec,
                           input int stall, input int abort_at,
                           output logic [63:0] res, output logic [55:0] rk0);
    logic [63:0] exp_out;
    logic [5:0]  e;
    int          w;
    exp_out = des_ref(m, key, dec);
    res = '0;
    rk0 = '0;
    w   = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    msg        = m;
    bus.in_key = key;
`ifdef DES_DECRYPT_EN
    bus.mode   = dec;
`endif
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_key   = 56'({$urandom, $urandom});
`ifdef DES_DECRYPT_EN
    bus.mode     = ~dec;
`endif
    chk("load_strobes", 64'(strobes()), 64'(6'b100001));
    for (int r = 0; r < ROUNDS; r++) begin
      @(negedge clk);
      e = {1'b0, 1'b1, (r == ROUNDS - 1), 3'b001};
      chk("round_strobes", 64'(strobes()), 64'(e));
      chk("rnd_idx", 64'(bus.rnd_idx), 64'(r));
      chk("round_key_cd", 64'(bus.round_key_cd), 64'(cd_ref(key, dec ? 16 - r : r + 1)));
      if (r == 0) rk0 = bus.round_key_cd;
      junk = {$urandom, $urandom};
      if (r == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_strobes", 64'(strobes()), 64'd0);
        chk("abort_rnd_idx", 64'(bus.rnd_idx), 64'd0);
        chk("abort_cd", 64'(bus.round_key_cd), 64'd0);
        chk("abort_out_data", bus.out_data, 64'd0);
        @(negedge clk);
        rst  = 1'b1;
        junk = '0;
        @(negedge clk);
        return;
      end
    end
    @(negedge clk);
    junk = '0;
    chk("capt_strobes", 64'(strobes()), 64'(6'b000001));
    chk("rnd_idx_hold", 64'(bus.rnd_idx), 64'(ROUNDS - 1));
    @(negedge clk);
    junk = {$urandom, $urandom};
    chk("out_strobes", 64'(strobes()), 64'(6'b000101));
    chk("out_data", bus.out_data, exp_out);
    res = bus.out_data;
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_key   = 56'({$urandom, $urandom});
      @(negedge clk);
      chk("stall_strobes", 64'(strobes()), 64'(6'b000101));
      chk("stall_data", bus.out_data, exp_out);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("idle_strobes", 64'(strobes()), 64'(6'b000010));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at %0t, limit 500000", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] res;
    logic [55:0] rk0;
    logic [55:0] k5;
    logic [55:0] k;
    logic [63:0] m;
    bus.in_valid  = 1'b0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;
`ifdef DES_DECRYPT_EN
    bus.mode      = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_strobes", 64'(strobes()), 64'd0);
    chk("rst_rnd_idx", 64'(bus.rnd_idx), 64'd0);
    chk("rst_cd", 64'(bus.round_key_cd), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release", 64'(strobes()), 64'(6'b000010));

    // Classic worked example: key schedule endpoints and ciphertext.
    k5 = pc1(64'h133457799BBCDFF1);
    chk("pc1_key", 64'(k5), 64'(56'hF0CCAAF556678F));
    run_block(k5, 64'h0123456789ABCDEF, 1'b0, 0, -1, res, rk0);
    chk("t5_cipher", res, 64'h85E813540F0AB405);
    chk("t1_k1", 64'(rk0), 64'(56'hE19955FAACCF1E));
    chk("t1_k16_hold", 64'(bus.round_key_cd), 64'(56'hF0CCAAF556678F));

    // Long backpressure, then abort mid-block and recover.
    run_block(56'({$urandom, $urandom}), {$urandom, $urandom}, 1'b0, 10, -1, res, rk0);
    run_block(56'({$urandom, $urandom}), {$urandom, $urandom}, 1'b0, 0, 7, res, rk0);
    run_block(56'({$urandom, $urandom}), {$urandom, $urandom}, 1'b0, 1, -1, res, rk0);

    for (int i = 0; i < 6; i++) begin
      k = 56'({$urandom, $urandom});
      m = {$urandom, $urandom};
      run_block(k, m, 1'b0, int'($urandom_range(0, 3)), -1, res, rk0);
    end

`ifdef DES_DECRYPT_EN
    run_block(k5, 64'h85E813540F0AB405, 1'b1, 0, -1, res, rk0);
    chk("t6_plain", res, 64'h0123456789ABCDEF);
    chk("t6_k16", 64'(rk0), 64'(56'hF0CCAAF556678F));
    chk("t6_k1_hold", 64'(bus.round_key_cd), 64'(56'hE19955FAACCF1E));
    for (int i = 0; i < 3; i++) begin
      k = 56'({$urandom, $urandom});
      m = {$urandom, $urandom};
      run_block(k, m, 1'b0, 0, -1, res, rk0);
      run_block(k, res, 1'b1, int'($urandom_range(0, 2)), -1, res, rk0);
      chk("roundtrip", res, m);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
